multicycle_controller: RTL
==========================

// Module: multicycle_controller
// PURPOSE
//   Moore-style control FSM that sequences a multicycle MIPS datapath: one shared memory,
//   instruction register, ALU reused for PC increment, branch target and data.
//   Replaces the single-cycle combinational control path; decodes opcode/funct from the IR.
//   Inserts memory wait states through a ready handshake.
//   Keeps a retired-instruction counter for the test bench and the board.
// PARAMETERS
//   CNT_W    32   width of the retired-instruction counter instr_count
// PORTS
//   clk          in   1      rising-edge clock; sole clock
//   Reset        in   1      synchronous, active-high reset
//   opcode       in   6      IR[31:26]
//   funct        in   6      IR[5:0]
//   zero         in   1      ALU zero flag, valid in BRANCH state
//   mem_ready    in   1      memory has completed the current read/write this cycle
//   iord         out  1      0: mem addr = PC; 1: mem addr = ALUOut
//   irwrite      out  1      load IR from memory read data
//   memwrite     out  1      memory write request
//   regwrite     out  1      register file write enable
//   regdst       out  1      0: rt; 1: rd is write register
//   memtoreg     out  1      0: ALUOut; 1: Data register to register file
//   alusrca      out  1      0: PC; 1: reg A
//   alusrcb      out  2      00: reg B, 01: const 4, 10: signimm, 11: signimm<<2
//   pcsrc        out  2      00: ALUResult, 01: ALUOut, 10: jump target
//   pcen         out  1      PC load = pcwrite | (branch & zero)
//   alucontrol   out  3      010 add, 110 sub, 000 and, 001 or, 111 slt
//   illegal_op   out  1      one-cycle pulse in DECODE on an unsupported opcode
//   instr_count  out  CNT_W  count of retired instructions
// BEHAVIOUR
//   State encoding: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC, ALUWB, BRANCH,
//     ADDIEX, ADDIWB, JUMP.
//   Reset:
//     - State is FETCH and instr_count is 0 on the edge after Reset is sampled high.
//     - While Reset is high, every control output is forced to 0 combinationally.
//     - A reset mid-instruction aborts it; no register or memory write is issued.
//   FETCH (iord=0, alusrca=0, alusrcb=01, alucontrol=add, pcsrc=00):
//     - irwrite and pcen are 1 only when mem_ready=1.
//     - Stay in FETCH while mem_ready=0. Go to DECODE when mem_ready=1.
//   DECODE (alusrca=0, alusrcb=11, alucontrol=add; branch target goes into ALUOut):
//     - lw/sw (100011/101011) -> MEMADR
//     - R-type (000000) -> EXEC
//     - beq (000100) -> BRANCH
//     - addi (001000) -> ADDIEX
//     - j (000010) -> JUMP
//     - any other opcode -> illegal_op=1 and return to FETCH; the instruction is not counted.
//   MEMADR (alusrca=1, alusrcb=10, add): lw -> MEMRD, sw -> MEMWR.
//   MEMRD (iord=1): wait for mem_ready, then MEMWB.
//   MEMWB (regdst=0, memtoreg=1, regwrite=1) -> FETCH.
//   MEMWR (iord=1, memwrite=1):
//     - memwrite is held high until the mem_ready cycle.
//     - Go to FETCH on mem_ready.
//   EXEC (alusrca=1, alusrcb=00): alucontrol is decoded from funct.
//     - funct mapping: 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt.
//     - Any other funct gives add.
//     - Next state ALUWB.
//   ALUWB (regdst=1, memtoreg=0, regwrite=1) -> FETCH.
//   BRANCH (alusrca=1, alusrcb=00, alucontrol=sub, pcsrc=01):
//     - pcen = zero.
//     - Next state FETCH.
//   ADDIEX (alusrca=1, alusrcb=10, add) -> ADDIWB.
//   ADDIWB (regdst=0, memtoreg=0, regwrite=1) -> FETCH.
//   JUMP (pcsrc=10, pcen=1) -> FETCH.
//   Default outputs: any output not listed for a state is 0.
//   Outputs depend only on state, plus mem_ready (FETCH, MEMWR) and zero (BRANCH).
//   Latency with mem_ready always 1:
//     - lw 5 cycles; sw, R-type, addi 4 cycles; beq, j 3 cycles.
//     - Each wait cycle adds 1.
//   instr_count:
//     - +1 on the final cycle of each instruction: MEMWB, MEMWR with ready, ALUWB,
//       BRANCH, ADDIWB, JUMP.
//     - Wraps modulo 2^CNT_W.
//   Unreachable state codes return to FETCH on the next edge.
// TESTING
//   - Reset held 2 cycles mid-MEMWR -> memwrite=0 during reset, state FETCH, instr_count=0.
//   - R-type add (funct 100000), mem_ready=1 -> FETCH, DECODE, EXEC (alucontrol=010),
//     ALUWB (regwrite=1, regdst=1), 4 cycles, instr_count +1.
//   - lw with mem_ready low 3 cycles in MEMRD -> 8 cycles total; regwrite=1 and memtoreg=1
//     exactly once.
//   - beq with zero=1 -> pcen=1, pcsrc=01 in BRANCH; with zero=0 -> pcen=0, PC unchanged.
//   - Opcode 111111 -> illegal_op pulses 1 cycle in DECODE, back to FETCH, no writes,
//     count unchanged.
//   - CNT_W=4, 17 j instructions -> instr_count wraps to 1; pcsrc=10 and pcen=1 on each JUMP.

Source files
------------

// File: rtl/multicycle_controller_if.sv
// Control bundle between the multicycle MIPS datapath and its controller.
// Datapath side (master) drives the decode fields, flags and memory ready;
// controller side (slave) drives every datapath control line and the
// retired-instruction count.
//   opcode/funct  IR[31:26] / IR[5:0]
//   zero          ALU zero flag
//   mem_ready     memory finished the current access this cycle
//   iord..illegal_op  datapath controls (see controller header)
//   instr_count   retired-instruction counter, CNT_W bits
interface multicycle_controller_if #(
    parameter int unsigned CNT_W = 32
);
    logic [5:0]       opcode;
    logic [5:0]       funct;
    logic             zero;
    logic             mem_ready;

    logic             iord;
    logic             irwrite;
    logic             memwrite;
    logic             regwrite;
    logic             regdst;
    logic             memtoreg;
    logic             alusrca;
    logic [1:0]       alusrcb;
    logic [1:0]       pcsrc;
    logic             pcen;
    logic [2:0]       alucontrol;
    logic             illegal_op;
    logic [CNT_W-1:0] instr_count;

    modport master (
        output opcode, funct, zero, mem_ready,
        input  iord, irwrite, memwrite, regwrite, regdst, memtoreg,
               alusrca, alusrcb, pcsrc, pcen, alucontrol, illegal_op,
               instr_count
    );

    modport slave (
        input  opcode, funct, zero, mem_ready,
        output iord, irwrite, memwrite, regwrite, regdst, memtoreg,
               alusrca, alusrcb, pcsrc, pcen, alucontrol, illegal_op,
               instr_count
    );
endinterface

// File: rtl/multicycle_controller.sv
// Moore control FSM for a multicycle MIPS datapath (shared memory, IR, one ALU
// reused for PC+4, branch target and data). Memory wait states come from the
// mem_ready handshake; a counter tallies retired instructions.
// Ports:
//   clk    rising-edge clock
//   Reset  synchronous active-high reset; forces every control output to 0
//   bus    slave side of multicycle_controller_if (decode inputs, controls,
//          instr_count)
// Control outputs are combinational from state, plus mem_ready in FETCH and
// MEMWR and zero in BRANCH; instr_count is registered.
module multicycle_controller #(
    parameter int unsigned CNT_W = 32
) (
    input  logic                   clk,
    input  logic                   Reset,
    multicycle_controller_if.slave bus
);
    localparam int unsigned OP_W  = 6;
    localparam int unsigned ALU_W = 3;

    localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
    localparam logic [OP_W-1:0] OP_J     = 6'b000010;

    localparam logic [ALU_W-1:0] ALU_ADD = 3'b010;
    localparam logic [ALU_W-1:0] ALU_SUB = 3'b110;
    localparam logic [ALU_W-1:0] ALU_AND = 3'b000;
    localparam logic [ALU_W-1:0] ALU_OR  = 3'b001;
    localparam logic [ALU_W-1:0] ALU_SLT = 3'b111;

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXEC   = 4'd6,
        ALUWB  = 4'd7,
        BRANCH = 4'd8,
        ADDIEX = 4'd9,
        ADDIWB = 4'd10,
        JUMP   = 4'd11
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic             iord_c, irwrite_c, memwrite_c, regwrite_c;
    logic             regdst_c, memtoreg_c, alusrca_c, pcen_c;
    logic [1:0]       alusrcb_c, pcsrc_c;
    logic [ALU_W-1:0] alucontrol_c;
    logic             illegal_op_c;
    logic             retire_c;

    // R-type ALU operation; unknown funct codes fall back to add
    function automatic logic [ALU_W-1:0] funct_alu(input logic [5:0] fn);
        case (fn)
            6'b100000: funct_alu = ALU_ADD;
            6'b100010: funct_alu = ALU_SUB;
            6'b100100: funct_alu = ALU_AND;
            6'b100101: funct_alu = ALU_OR;
            6'b101010: funct_alu = ALU_SLT;
            default:   funct_alu = ALU_ADD;
        endcase
    endfunction

    // State and retired-instruction counter
    always_ff @(posedge clk) begin
        if (Reset) begin
            state_q <= FETCH;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    // Next state and control decode
    always_comb begin
        state_d      = state_q;
        iord_c       = 1'b0;
        irwrite_c    = 1'b0;
        memwrite_c   = 1'b0;
        regwrite_c   = 1'b0;
        regdst_c     = 1'b0;
        memtoreg_c   = 1'b0;
        alusrca_c    = 1'b0;
        alusrcb_c    = 2'b00;
        pcsrc_c      = 2'b00;
        pcen_c       = 1'b0;
        alucontrol_c = ALU_AND;
        illegal_op_c = 1'b0;
        retire_c     = 1'b0;

        case (state_q)
            FETCH: begin
                alusrcb_c    = 2'b01;
                alucontrol_c = ALU_ADD;
                // IR load and PC+4 only commit once memory delivers the word
                irwrite_c    = bus.mem_ready;
                pcen_c       = bus.mem_ready;
                if (bus.mem_ready) state_d = DECODE;
            end
            DECODE: begin
                // Speculatively form the branch target into ALUOut
                alusrcb_c    = 2'b11;
                alucontrol_c = ALU_ADD;
                case (bus.opcode)
                    OP_LW, OP_SW: state_d = MEMADR;
                    OP_RTYPE:     state_d = EXEC;
                    OP_BEQ:       state_d = BRANCH;
                    OP_ADDI:      state_d = ADDIEX;
                    OP_J:         state_d = JUMP;
                    default: begin
                        illegal_op_c = 1'b1;
                        state_d      = FETCH;
                    end
                endcase
            end
            MEMADR: begin
                alusrca_c    = 1'b1;
                alusrcb_c    = 2'b10;
                alucontrol_c = ALU_ADD;
                state_d      = (bus.opcode == OP_SW) ? MEMWR : MEMRD;
            end
            MEMRD: begin
                iord_c = 1'b1;
                if (bus.mem_ready) state_d = MEMWB;
            end
            MEMWB: begin
                memtoreg_c = 1'b1;
                regwrite_c = 1'b1;
                retire_c   = 1'b1;
                state_d    = FETCH;
            end
            MEMWR: begin
                iord_c     = 1'b1;
                memwrite_c = 1'b1;
                if (bus.mem_ready) begin
                    retire_c = 1'b1;
                    state_d  = FETCH;
                end
            end
            EXEC: begin
                alusrca_c    = 1'b1;
                alucontrol_c = funct_alu(bus.funct);
                state_d      = ALUWB;
            end
            ALUWB: begin
                regdst_c   = 1'b1;
                regwrite_c = 1'b1;
                retire_c   = 1'b1;
                state_d    = FETCH;
            end
            BRANCH: begin
                alusrca_c    = 1'b1;
                alucontrol_c = ALU_SUB;
                pcsrc_c      = 2'b01;
                pcen_c       = bus.zero;
                retire_c     = 1'b1;
                state_d      = FETCH;
            end
            ADDIEX: begin
                alusrca_c    = 1'b1;
                alusrcb_c    = 2'b10;
                alucontrol_c = ALU_ADD;
                state_d      = ADDIWB;
            end
            ADDIWB: begin
                regwrite_c = 1'b1;
                retire_c   = 1'b1;
                state_d    = FETCH;
            end
            JUMP: begin
                pcsrc_c  = 2'b10;
                pcen_c   = 1'b1;
                retire_c = 1'b1;
                state_d  = FETCH;
            end
            default: state_d = FETCH;
        endcase

        // Reset aborts the instruction in flight: no writes, no PC update
        if (Reset) begin
            iord_c       = 1'b0;
            irwrite_c    = 1'b0;
            memwrite_c   = 1'b0;
            regwrite_c   = 1'b0;
            regdst_c     = 1'b0;
            memtoreg_c   = 1'b0;
            alusrca_c    = 1'b0;
            alusrcb_c    = 2'b00;
            pcsrc_c      = 2'b00;
            pcen_c       = 1'b0;
            alucontrol_c = '0;
            illegal_op_c = 1'b0;
            retire_c     = 1'b0;
        end

        count_d = retire_c ? count_q + CNT_W'(1) : count_q;
    end

    assign bus.iord        = iord_c;
    assign bus.irwrite     = irwrite_c;
    assign bus.memwrite    = memwrite_c;
    assign bus.regwrite    = regwrite_c;
    assign bus.regdst      = regdst_c;
    assign bus.memtoreg    = memtoreg_c;
    assign bus.alusrca     = alusrca_c;
    assign bus.alusrcb     = alusrcb_c;
    assign bus.pcsrc       = pcsrc_c;
    assign bus.pcen        = pcen_c;
    assign bus.alucontrol  = alucontrol_c;
    assign bus.illegal_op  = illegal_op_c;
    assign bus.instr_count = count_q;
endmodule
